// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: valid/ready/addr/rdata/wdata/wstrb bundle.
// master issues requests, slave answers with ready/rdata.
interface mem_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data 2:1 arbiter onto one memory port.
// Optional ARB_TIMEOUT_EN adds an m_ready timeout with bus_err.
module mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  i_bus,
  mem_arbiter_if.slave  d_bus,
  mem_arbiter_if.master m_bus,
  output logic          bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("mem_arbiter: parameter out of range");
  end

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic        tmo_hit;
  logic        done;
  logic        pick_d;
  logic        pick_i;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_q, tmo_d;

  // count wait cycles of the current grant, zero while idle
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == IDLE)
      tmo_d = '0;
    else if (!m_bus.ready)
      tmo_d = tmo_q + 16'd1;
  end

  // wait counter register
  always_ff @(posedge clk) begin
    if (reset)
      tmo_q <= '0;
    else
      tmo_q <= tmo_d;
  end

  assign tmo_hit = (state_q != IDLE) && !m_bus.ready &&
                   (tmo_q == TMO_LAST);
  assign bus_err = tmo_hit;
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign done = (state_q != IDLE) && (m_bus.ready || tmo_hit);

  assign pick_d = d_bus.valid &&
                  (!i_bus.valid || (starve_q < LIMIT));
  assign pick_i = i_bus.valid && !pick_d;

  assign i_bus.ready = (state_q == GRANT_I) && done;
  assign d_bus.ready = (state_q == GRANT_D) && done;
  assign i_bus.rdata = tmo_hit ? '0 : m_bus.rdata;
  assign d_bus.rdata = tmo_hit ? '0 : m_bus.rdata;

  assign m_bus.valid = m_valid_q;
  assign m_bus.addr  = m_addr_q;
  assign m_bus.wdata = m_wdata_q;
  assign m_bus.wstrb = m_wstrb_q;

  // arbitration in IDLE, completion while granted
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_d: begin
            state_d   = GRANT_D;
            m_valid_d = 1'b1;
            m_addr_d  = d_bus.addr;
            m_wdata_d = d_bus.wdata;
            m_wstrb_d = d_bus.wstrb;
            starve_d  = i_bus.valid ? starve_q + 4'd1 : 4'd0;
          end
          pick_i: begin
            state_d   = GRANT_I;
            m_valid_d = 1'b1;
            m_addr_d  = i_bus.addr;
            m_wdata_d = i_bus.wdata;
            m_wstrb_d = i_bus.wstrb;
            starve_d  = 4'd0;
          end
          default: ;
        endcase
      end
      GRANT_I, GRANT_D: begin
        if (done) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          m_wstrb_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and memory-side request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

endmodule
